// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the tartaruga execute-stage multiply/divide unit.
package tartaruga_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_t;

    localparam int          MULDIV_ITERS = 32;
    localparam logic [31:0] DIV_ZERO_Q   = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;

    function automatic logic op_is_div(muldiv_op_t op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic op_is_rem(muldiv_op_t op);
        return op inside {REM, REMU};
    endfunction

    // MULHSU is the odd one out: rs1 is signed, rs2 is unsigned.
    function automatic logic op_rs1_signed(muldiv_op_t op);
        return op inside {MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic op_rs2_signed(muldiv_op_t op);
        return op inside {MULH, DIV, REM};
    endfunction

endpackage

// File: rtl/exe_muldiv_if.sv
// Request/response bundle between the execute-stage issue logic (master) and the mul/div unit (slave).
interface exe_muldiv_if import tartaruga_pkg::*; #(
    parameter int XLEN = 32
) ();

    logic            req_valid_i;
    logic            req_ready_o;
    muldiv_op_t      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            kill_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] result_o;
    logic            busy_o;

    modport master (
        output req_valid_i, op_i, rs1_i, rs2_i, kill_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, result_o, busy_o
    );

    modport slave (
        input  req_valid_i, op_i, rs1_i, rs2_i, kill_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, result_o, busy_o
    );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes on accept, result negation/selection on the final iteration.
module muldiv_sign_fix import tartaruga_pkg::*; (
    input  muldiv_op_t  acc_op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] mag1_o,
    output logic [31:0] mag2_o,
    output logic        res_neg_o,
    output logic        rem_neg_o,
    input  muldiv_op_t  fix_op_i,
    input  logic        res_neg_i,
    input  logic        rem_neg_i,
    input  logic [63:0] prod_i,
    input  logic [31:0] quot_i,
    input  logic [31:0] rem_i,
    output logic [31:0] result_o
);

    logic        neg1;
    logic        neg2;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_comb begin
        neg1      = op_rs1_signed(acc_op_i) && rs1_i[31];
        neg2      = op_rs2_signed(acc_op_i) && rs2_i[31];
        // INT_MIN negates to itself, which is exactly its unsigned magnitude.
        mag1_o    = neg1 ? -rs1_i : rs1_i;
        mag2_o    = neg2 ? -rs2_i : rs2_i;
        res_neg_o = neg1 ^ neg2;
        rem_neg_o = neg1;
    end

    always_comb begin
        prod_fix = res_neg_i ? -prod_i : prod_i;
        quot_fix = res_neg_i ? -quot_i : quot_i;
        rem_fix  = rem_neg_i ? -rem_i  : rem_i;
        unique case (fix_op_i)
            MUL:                 result_o = prod_fix[31:0];
            MULH, MULHSU, MULHU: result_o = prod_fix[63:32];
            DIV, DIVU:           result_o = quot_fix;
            default:             result_o = rem_fix;
        endcase
    end

endmodule

// File: rtl/exe_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define TARTARUGA_MULDIV_FAST_MUL_EN to complete MUL-class ops in one cycle on a 33x33 multiplier.
module exe_muldiv import tartaruga_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    exe_muldiv_if.slave  bus
);

    muldiv_state_t   state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    muldiv_op_t      op_q, op_d;
    logic [63:0]     acc_q, acc_d;
    logic [31:0]     rem_q, rem_d;
    logic [31:0]     opb_q, opb_d;
    logic            res_neg_q, res_neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic [XLEN-1:0] result_q, result_d;

    logic        accept;
    logic [31:0] mag1, mag2;
    logic        acc_res_neg, acc_rem_neg;
    logic [31:0] fix_result;

    logic        fast_div_zero, fast_div_ovf;
    logic [31:0] fast_div_res;
    logic        fast_mul;
    logic [31:0] fast_mul_res;

    logic [32:0] mul_sum;
    logic [63:0] mul_acc;
    logic [32:0] rem_sh;
    logic [31:0] div_trial;
    logic        div_ge;
    logic [63:0] step_acc;
    logic [31:0] step_rem;

    assign bus.req_ready_o = (state_q == IDLE) && !rst_i;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.rsp_valid_o = (state_q == DONE);
    assign bus.result_o    = result_q;

    assign accept = bus.req_ready_o && bus.req_valid_i && !bus.kill_i;

    muldiv_sign_fix u_sign_fix (
        .acc_op_i  (bus.op_i),
        .rs1_i     (bus.rs1_i),
        .rs2_i     (bus.rs2_i),
        .mag1_o    (mag1),
        .mag2_o    (mag2),
        .res_neg_o (acc_res_neg),
        .rem_neg_o (acc_rem_neg),
        .fix_op_i  (op_q),
        .res_neg_i (res_neg_q),
        .rem_neg_i (rem_neg_q),
        .prod_i    (step_acc),
        .quot_i    (step_acc[31:0]),
        .rem_i     (step_rem),
        .result_o  (fix_result)
    );

    always_comb begin
        fast_div_zero = op_is_div(bus.op_i) && (bus.rs2_i == '0);
        fast_div_ovf  = (bus.op_i inside {DIV, REM}) && (bus.rs1_i == INT_MIN) && (bus.rs2_i == '1);
        if (fast_div_zero) fast_div_res = op_is_rem(bus.op_i) ? bus.rs1_i : DIV_ZERO_Q;
        else               fast_div_res = op_is_rem(bus.op_i) ? '0 : INT_MIN;
    end

`ifdef TARTARUGA_MULDIV_FAST_MUL_EN
    logic signed [32:0] fm_a, fm_b;
    logic signed [63:0] fm_prod;

    assign fm_a         = {op_rs1_signed(bus.op_i) && bus.rs1_i[31], bus.rs1_i};
    assign fm_b         = {op_rs2_signed(bus.op_i) && bus.rs2_i[31], bus.rs2_i};
    assign fm_prod      = 64'(fm_a) * 64'(fm_b);
    assign fast_mul     = !op_is_div(bus.op_i);
    assign fast_mul_res = (bus.op_i == MUL) ? fm_prod[31:0] : fm_prod[63:32];
`else
    assign fast_mul     = 1'b0;
    assign fast_mul_res = '0;
`endif

    // One iteration step. Multiply keeps the multiplier in acc[31:0] and shifts the
    // product in from the top; divide shifts the dividend out of acc[31:0] and the quotient in.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_acc   = {mul_sum, acc_q[31:1]};
        rem_sh    = {rem_q, acc_q[31]};
        div_ge    = (rem_sh >= {1'b0, opb_q});
        div_trial = rem_sh[31:0] - opb_q;
        if (op_is_div(op_q)) begin
            step_acc = {acc_q[63:32], acc_q[30:0], div_ge};
            step_rem = div_ge ? div_trial : rem_sh[31:0];
        end else begin
            step_acc = mul_acc;
            step_rem = rem_q;
        end
    end

    // NOTE: every variable gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        opb_d     = opb_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = bus.op_i;
                    acc_d     = {32'd0, mag1};
                    rem_d     = '0;
                    opb_d     = mag2;
                    res_neg_d = acc_res_neg;
                    rem_neg_d = acc_rem_neg;
                    cnt_d     = '0;
                    if (fast_div_zero || fast_div_ovf) begin
                        state_d  = DONE;
                        result_d = fast_div_res;
                    end else if (fast_mul) begin
                        state_d  = DONE;
                        result_d = fast_mul_res;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.kill_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc;
                    rem_d = step_rem;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(MULDIV_ITERS - 1)) begin
                        state_d  = DONE;
                        result_d = fix_result;
                    end
                end
            end
            DONE: begin
                if (bus.kill_i || bus.rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on accept before being read.
    always_ff @(posedge clk_i) begin
        cnt_q     <= cnt_d;
        op_q      <= op_d;
        acc_q     <= acc_d;
        rem_q     <= rem_d;
        opb_q     <= opb_d;
        res_neg_q <= res_neg_d;
        rem_neg_q <= rem_neg_d;
    end

endmodule
